// File: rtl/task_ctrl_pkg.sv
// Shared encodings for the task controller: FSM states, destination codes,
// execution latencies and OPCODE field helpers.
package task_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_IO  = 4'd2,
        ST_EXEC_ALU = 4'd3,
        ST_EXEC_MEM = 4'd4,
        ST_ERROR    = 4'd5,
        ST_DONE     = 4'd6
    } state_e;

    localparam logic [1:0] DEST_IO  = 2'd0;
    localparam logic [1:0] DEST_ALU = 2'd1;
    localparam logic [1:0] DEST_MEM = 2'd2;
    localparam logic [1:0] DEST_INV = 2'd3;

    localparam logic [3:0] LAT_IO  = 4'd3;
    localparam logic [3:0] LAT_ALU = 4'd2;
    localparam logic [3:0] LAT_MEM = 4'd4;

    localparam int OP_RW_BIT   = 0;
    localparam int OP_DEST_LSB = 1;
    localparam int OP_TID_LSB  = 3;

    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 4;

    function automatic logic op_rw(input logic [4:0] op);
        return op[OP_RW_BIT];
    endfunction

    function automatic logic [1:0] op_dest(input logic [4:0] op);
        return op[OP_DEST_LSB +: 2];
    endfunction

    function automatic logic [1:0] op_tid(input logic [4:0] op);
        return op[OP_TID_LSB +: 2];
    endfunction

endpackage

// File: rtl/task_mem.sv
// Four-entry data memory indexed by transID: synchronous write,
// combinational read, cleared by the asynchronous reset.
module task_mem
    import task_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              a_rst,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:MEM_DEPTH-1];

    // Storage array with async clear and single write port
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/task_controller.sv
// Task scheduler: captures one opcode per task, runs it on the IO register,
// ALU accumulator or task memory for a fixed latency, then pulses READY.
module task_controller
    import task_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       a_rst,
    input  logic [4:0] OPCODE,
    input  logic [7:0] WDATA,
    input  logic [7:0] task_num,
    output logic       READY,
    output logic [3:0] state,
    output logic [3:0] count
);

    state_e            state_r;
    logic [3:0]        count_r;
    logic [4:0]        cur_op_r;
    logic [DATA_W-1:0] cur_data_r;
    logic [7:0]        cur_task_r;
    logic [DATA_W-1:0] io_reg_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] rd_reg_r;
    logic [7:0]        err_cnt_r;

    logic              mem_we_s;
    logic [1:0]        mem_addr_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Memory write commits only on the final EXEC_MEM cycle of a write task
    assign mem_addr_s = op_tid(cur_op_r);
    assign mem_we_s   = (state_r == ST_EXEC_MEM) && (count_r == LAT_MEM - 4'd1)
                        && op_rw(cur_op_r);

    task_mem u_mem (
        .clk   (clk),
        .a_rst (a_rst),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (cur_data_r),
        .rdata (mem_rdata_s)
    );

    // Main FSM: task capture, dispatch, latency counting and side-effect commit
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_r    <= ST_IDLE;
            count_r    <= 4'd0;
            cur_op_r   <= 5'd0;
            cur_data_r <= 8'd0;
            cur_task_r <= 8'd0;
            io_reg_r   <= 8'd0;
            acc_r      <= 8'd0;
            rd_reg_r   <= 8'd0;
            err_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cur_op_r   <= OPCODE;
                    cur_data_r <= WDATA;
                    cur_task_r <= task_num;
                    count_r    <= 4'd0;
                    state_r    <= ST_DECODE;
                end
                ST_DECODE: begin
                    count_r <= 4'd0;
                    case (op_dest(cur_op_r))
                        DEST_IO:  state_r <= ST_EXEC_IO;
                        DEST_ALU: state_r <= ST_EXEC_ALU;
                        DEST_MEM: state_r <= ST_EXEC_MEM;
                        DEST_INV: state_r <= ST_ERROR;
                        default:  state_r <= ST_ERROR;
                    endcase
                end
                ST_EXEC_IO: begin
                    if (count_r == LAT_IO - 4'd1) begin
                        count_r <= 4'd0;
                        state_r <= ST_DONE;
                        if (op_rw(cur_op_r)) io_reg_r <= cur_data_r;
                        else                 rd_reg_r <= io_reg_r;
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end
                ST_EXEC_ALU: begin
                    if (count_r == LAT_ALU - 4'd1) begin
                        count_r <= 4'd0;
                        state_r <= ST_DONE;
                        if (op_rw(cur_op_r)) acc_r    <= acc_r + cur_data_r;
                        else                 rd_reg_r <= acc_r;
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end
                ST_EXEC_MEM: begin
                    // the write itself happens inside u_mem via mem_we_s
                    if (count_r == LAT_MEM - 4'd1) begin
                        count_r <= 4'd0;
                        state_r <= ST_DONE;
                        if (!op_rw(cur_op_r)) rd_reg_r <= mem_rdata_s;
                    end else begin
                        count_r <= count_r + 4'd1;
                    end
                end
                ST_ERROR: begin
                    count_r <= 4'd0;
                    state_r <= ST_DONE;
                    if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
                end
                ST_DONE: begin
                    count_r <= 4'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    count_r <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign READY = (state_r == ST_DONE);
    assign state = state_r;
    assign count = count_r;

endmodule

// File: tb/tb_task_controller.sv
// Directed and random task sequences checked against a behavioural model of
// the resources and per-task state/count timelines.
module tb_task_controller;

    logic       clk = 1'b0;
    logic       a_rst;
    logic [4:0] OPCODE;
    logic [7:0] WDATA;
    logic [7:0] task_num;
    logic       READY;
    logic [3:0] state;
    logic [3:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] m_io, m_acc, m_rd, m_err;
    logic [7:0] m_mem [4];

    task_controller dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .OPCODE   (OPCODE),
        .WDATA    (WDATA),
        .task_num (task_num),
        .READY    (READY),
        .state    (state),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_io = 8'd0; m_acc = 8'd0; m_rd = 8'd0; m_err = 8'd0;
        for (int i = 0; i < 4; i++) m_mem[i] = 8'd0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " io_reg"},  dut.io_reg_r,  m_io);
        chk({tag, " acc"},     dut.acc_r,     m_acc);
        chk({tag, " rd_reg"},  dut.rd_reg_r,  m_rd);
        chk({tag, " err_cnt"}, dut.err_cnt_r, m_err);
        for (int i = 0; i < 4; i++) chk({tag, " mem"}, dut.u_mem.mem_r[i], m_mem[i]);
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at the next IDLE.
    task automatic run_task(input string tag, input logic [4:0] op,
                            input logic [7:0] data, input logic [7:0] num);
        int st[$];
        int ct[$];
        int dest, lat;
        dest = int'(op[2:1]);
        lat  = (dest == 0) ? 3 : (dest == 1) ? 2 : (dest == 2) ? 4 : 0;
        OPCODE = op; WDATA = data; task_num = num;
        st.push_back(0); ct.push_back(0);
        st.push_back(1); ct.push_back(0);
        if (dest == 3) begin
            st.push_back(5); ct.push_back(0);
        end else begin
            for (int i = 0; i < lat; i++) begin
                st.push_back(2 + dest); ct.push_back(i);
            end
        end
        st.push_back(6); ct.push_back(0);
        for (int k = 0; k < st.size(); k++) begin
            chk({tag, " state"}, state, st[k]);
            chk({tag, " count"}, count, ct[k]);
            chk({tag, " READY"}, READY, (st[k] == 6) ? 1 : 0);
            if (k == 1) chk({tag, " cur_task"}, dut.cur_task_r, num);
            if (k >= 1) begin
                // inputs outside IDLE must be ignored
                OPCODE = 5'($urandom); WDATA = 8'($urandom); task_num = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        case (dest)
            0: if (op[0]) m_io = data; else m_rd = m_io;
            1: if (op[0]) m_acc = m_acc + data; else m_rd = m_acc;
            2: if (op[0]) m_mem[op[4:3]] = data; else m_rd = m_mem[op[4:3]];
            default: m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        endcase
        chk({tag, " back in IDLE"}, state, 0);
        chk_regs(tag);
    endtask

    initial begin
        logic [4:0] rop;
        a_rst = 1'b1; OPCODE = 5'd0; WDATA = 8'd0; task_num = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset state", state, 0);
        chk("reset count", count, 0);
        chk("reset READY", READY, 0);
        chk_regs("reset");
        a_rst = 1'b0;

        // abort a MEM write at count 2
        OPCODE = 5'b10101; WDATA = 8'h3C; task_num = 8'd1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-abort state", state, 4);
        chk("pre-abort count", count, 2);
        a_rst = 1'b1;
        #1;
        chk("abort state", state, 0);
        chk("abort count", count, 0);
        chk("abort READY", READY, 0);
        chk("abort mem2", dut.u_mem.mem_r[2], 8'h00);
        @(negedge clk);
        a_rst = 1'b0;
        model_reset();

        run_task("io write",  5'b00001, 8'hA5, 8'd10);
        run_task("alu wr f0", 5'b00011, 8'hF0, 8'd11);
        run_task("alu wr 20", 5'b00011, 8'h20, 8'd12);
        run_task("alu read",  5'b00010, 8'h00, 8'd13);
        chk("alu wrap rd", dut.rd_reg_r, 8'h10);
        run_task("mem wr t2", 5'b10101, 8'h3C, 8'd14);
        run_task("mem wr t1", 5'b01101, 8'h7E, 8'd15);
        run_task("mem rd t2", 5'b10100, 8'h00, 8'd16);
        chk("mem rd value", dut.rd_reg_r, 8'h3C);
        run_task("invalid",   5'b00111, 8'h55, 8'd17);
        chk("err_cnt one", dut.err_cnt_r, 8'd1);
        run_task("io read",   5'b00000, 8'h00, 8'd18);

        for (int n = 0; n < 200; n++) begin
            rop = {2'($urandom), 2'($urandom_range(2, 0)), 1'($urandom)};
            run_task("random", rop, 8'($urandom), 8'(n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
